// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus arbiter slice.
// Holds FSM state encoding, IO address map and access size codes.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [31:0] IO_IN_ADDR  = 32'h0000_0000;
    localparam logic [31:0] IO_OUT_ADDR = 32'h0000_0004;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/io_arb_pick.sv
// Two-way winner select: req[1:0], last -> win (0=m0, 1=m1).
// Round-robin when IO_BUS_ARBITER_RR_EN is defined, else m0 has priority.
module io_arb_pick
    import io_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);

`ifdef IO_BUS_ARBITER_RR_EN
    // On a tie the requester that did not win last time goes first.
    always_comb begin
        win = 1'b0;
        unique case (req)
            2'b11:   win = ~last;
            2'b10:   win = 1'b1;
            default: win = 1'b0;
        endcase
    end
`else
    logic unused_last;

    assign unused_last = last;
    assign win         = ~req[0] & req[1];
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the IO register block between m0 (LSU) and m1 (debug/loader).
// Ports: clk, rstn, m0_*/m1_* requester buses, t_* target bus.
// Option: IO_BUS_ARBITER_RR_EN selects round-robin instead of m0 priority.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [2:0]    m0_size,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rd,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [2:0]    m1_size,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rd,

    output logic          t_we,
    output logic [AW-1:0] t_addr,
    output logic [2:0]    t_size,
    output logic [DW-1:0] t_wd,
    input  logic [DW-1:0] t_rd
);

    state_t     state;
    state_t     state_n;
    logic       sel;
    logic       sel_n;
    logic       last;
    logic       last_n;
    logic       win;
    logic [1:0] req;

    assign req = {m1_req, m0_req};

    io_arb_pick u_pick (
        .req  (req),
        .last (last),
        .win  (win)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        last_n    = last;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rd     = '0;
        m1_rd     = '0;
        t_we      = 1'b0;
        t_addr    = '0;
        t_size    = '0;
        t_wd      = '0;

        unique case (state)
            IDLE: ;
            GRANT: begin
                state_n = RESP;
                if (sel) begin
                    m1_gnt = 1'b1;
                    t_we   = m1_we;
                    t_addr = m1_addr;
                    t_size = m1_size;
                    t_wd   = m1_wd;
                end else begin
                    m0_gnt = 1'b1;
                    t_we   = m0_we;
                    t_addr = m0_addr;
                    t_size = m0_size;
                    t_wd   = m0_wd;
                end
            end
            RESP: begin
                // Writes also complete here; rd is whatever t_rd holds.
                if (sel) begin
                    m1_rvalid = 1'b1;
                    m1_rd     = t_rd;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rd     = t_rd;
                end
            end
            default: state_n = IDLE;
        endcase

        // Arbitrate from IDLE and from RESP so back-to-back costs 2 cycles.
        if (state == IDLE || state == RESP) begin
            if (|req) begin
                state_n = GRANT;
                sel_n   = win;
                last_n  = win;
            end else begin
                state_n = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized scoreboard bench for io_bus_arbiter.
// Transaction-level model predicts grant/completion timing and read data.
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wd;
    } txn_t;

    typedef struct {
        int          cyc;
        bit          rv;
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wd;
        logic [31:0] rd;
    } ev_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;

    logic [1:0]       mreq = '0;
    logic [1:0]       mwe = '0;
    logic [1:0][31:0] maddr = '0;
    logic [1:0][2:0]  msize = '0;
    logic [1:0][31:0] mwd = '0;
    logic [1:0]       mgnt;
    logic [1:0]       mrv;
    logic [31:0]      m0_rd;
    logic [31:0]      m1_rd;
    logic             t_we;
    logic [31:0]      t_addr;
    logic [2:0]       t_size;
    logic [31:0]      t_wd;
    logic [31:0]      t_rd = '0;

    logic [31:0] io_in = '0;
    logic [31:0] out_reg = '0;

    txn_t pend0[$];
    txn_t pend1[$];
    ev_t  exp_q[$];

    int   cyc = 0;
    int   next_free = 0;
    bit   last_m = 1'b1;
    logic [31:0] model_out = '0;
    logic [1:0]  gnt_seen = '0;
    bit   drop_early = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   to_req = 0;
    int   to_seen = 0;

    io_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m0_req    (mreq[0]),
        .m0_we     (mwe[0]),
        .m0_addr   (maddr[0]),
        .m0_size   (msize[0]),
        .m0_wd     (mwd[0]),
        .m0_gnt    (mgnt[0]),
        .m0_rvalid (mrv[0]),
        .m0_rd     (m0_rd),
        .m1_req    (mreq[1]),
        .m1_we     (mwe[1]),
        .m1_addr   (maddr[1]),
        .m1_size   (msize[1]),
        .m1_wd     (mwd[1]),
        .m1_gnt    (mgnt[1]),
        .m1_rvalid (mrv[1]),
        .m1_rd     (m1_rd),
        .t_we      (t_we),
        .t_addr    (t_addr),
        .t_size    (t_size),
        .t_wd      (t_wd),
        .t_rd      (t_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // IO register block: registered read, one writable output register.
    always @(posedge clk) begin
        if (t_we && t_addr == IO_OUT_ADDR) out_reg <= t_wd;
        if (t_addr == IO_IN_ADDR)       t_rd <= io_in;
        else if (t_addr == IO_OUT_ADDR) t_rd <= out_reg;
        else                            t_rd <= '0;
    end

    function automatic int pick(input logic [1:0] r, input bit lst);
`ifdef IO_BUS_ARBITER_RR_EN
        if (r == 2'b11) return lst ? 0 : 1;
        return r[1] ? 1 : 0;
`else
        return r[0] ? 0 : 1;
`endif
    endfunction

    function automatic logic [31:0] read_val(input logic [31:0] a);
        if (a == IO_IN_ADDR)  return io_in;
        if (a == IO_OUT_ADDR) return model_out;
        return 32'h0;
    endfunction

    task automatic present(input int m, input txn_t t);
        mreq[m]  = 1'b1;
        mwe[m]   = t.we;
        maddr[m] = t.addr;
        msize[m] = t.size;
        mwd[m]   = t.wd;
    endtask

    // Requester drivers: hold until gnt, then drop or issue the next one.
    always begin
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (mreq[m] && gnt_seen[m]) mreq[m] = 1'b0;
            if (!mreq[m]) begin
                if (m == 0 && pend0.size() > 0)
                    present(0, pend0.pop_front());
                else if (m == 1 && pend1.size() > 0)
                    present(1, pend1.pop_front());
            end
        end
        @(negedge clk);
        gnt_seen = mgnt;
        if (mgnt[0] && drop_early) mreq[0] = 1'b0;
    end

    // Reference model: one access at a time, gnt 1 cycle after the
    // arbitration point, completion 1 cycle later, next pick at completion.
    always @(negedge clk) begin
        ev_t g;
        ev_t r;
        int  w;
        if (!rstn) begin
            exp_q.delete();
            next_free = 0;
            last_m    = 1'b1;
        end else if (cyc >= next_free && mreq != 2'b00) begin
            w      = pick(mreq, last_m);
            last_m = (w == 1);
            g.cyc  = cyc + 1;
            g.rv   = 1'b0;
            g.m    = w;
            g.we   = mwe[w];
            g.addr = maddr[w];
            g.size = msize[w];
            g.wd   = mwd[w];
            g.rd   = '0;
            r      = g;
            r.cyc  = cyc + 2;
            r.rv   = 1'b1;
            r.rd   = read_val(maddr[w]);
            if (mwe[w] && maddr[w] == IO_OUT_ADDR) model_out = mwd[w];
            exp_q.push_back(g);
            exp_q.push_back(r);
            next_free = cyc + 2;
        end
    end

    // Monitor: every cycle, all outputs must match the expected events.
    always @(negedge clk) begin
        ev_t         e;
        logic [1:0]  x_gnt;
        logic [1:0]  x_rv;
        logic        x_we;
        logic [31:0] x_addr;
        logic [2:0]  x_size;
        logic [31:0] x_wd;
        logic [31:0] x_rd0;
        logic [31:0] x_rd1;
        x_gnt = '0; x_rv = '0; x_we = 1'b0; x_addr = '0;
        x_size = '0; x_wd = '0; x_rd0 = '0; x_rd1 = '0;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (rstn && e.cyc == cyc) begin
                if (!e.rv) begin
                    x_gnt[e.m] = 1'b1;
                    x_we   = e.we;
                    x_addr = e.addr;
                    x_size = e.size;
                    x_wd   = e.wd;
                end else begin
                    x_rv[e.m] = 1'b1;
                    if (e.m == 0) x_rd0 = e.rd;
                    else          x_rd1 = e.rd;
                end
            end
        end
        n_checks++;
        if (mgnt !== x_gnt || mrv !== x_rv || t_we !== x_we ||
            t_addr !== x_addr || t_size !== x_size || t_wd !== x_wd ||
            m0_rd !== x_rd0 || m1_rd !== x_rd1) begin
            n_fail++;
            $display("FAIL cycle %0d outputs: got gnt=%b rv=%b we=%b addr=%h size=%h wd=%h rd0=%h rd1=%h, required gnt=%b rv=%b we=%b addr=%h size=%h wd=%h rd0=%h rd1=%h",
                     cyc, mgnt, mrv, t_we, t_addr, t_size, t_wd, m0_rd, m1_rd,
                     x_gnt, x_rv, x_we, x_addr, x_size, x_wd, x_rd0, x_rd1);
        end
        if (to_req != to_seen) begin
            n_checks += to_req - to_seen;
            n_fail   += to_req - to_seen;
            to_seen   = to_req;
        end
    end

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || mreq != 2'b00 ||
                exp_q.size() > 0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) begin
            $display("FAIL drain timeout: got %0d events pending, required 0", exp_q.size());
            to_req++;
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] a,
                                input logic [2:0] s, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.size = s; t.wd = d;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        logic [31:0] a;
        case ($urandom_range(3, 0))
            0:       a = IO_IN_ADDR;
            1:       a = IO_OUT_ADDR;
            2:       a = 32'h8;
            default: a = $urandom & 32'hFFFF_FFFC;
        endcase
        return mk(1'($urandom_range(1, 0)), a,
                  3'($urandom_range(2, 0)), $urandom);
    endfunction

    initial begin
        int k;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        repeat (5) @(negedge clk);

        pend0.push_back(mk(1'b1, IO_OUT_ADDR, SIZE_WORD, 32'hDEAD_BEEF));
        drain(50);
        pend1.push_back(mk(1'b0, IO_OUT_ADDR, SIZE_WORD, 32'h0));
        drain(50);

        io_in = 32'h1234_5678;
        pend1.push_back(mk(1'b0, IO_IN_ADDR, SIZE_WORD, 32'h0));
        drain(50);

        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            pend0.push_back(mk(1'b0, IO_IN_ADDR, SIZE_WORD, 32'h0));
            pend1.push_back(mk(1'b0, IO_OUT_ADDR, SIZE_HALF, 32'h0));
        end
        drain(200);

        drop_early = 1'b1;
        pend0.push_back(mk(1'b0, IO_OUT_ADDR, SIZE_BYTE, 32'h0));
        drain(50);
        drop_early = 1'b0;

        pend0.push_back(mk(1'b0, IO_IN_ADDR, SIZE_WORD, 32'h0));
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mgnt[0] && k < 20);
        if (!mgnt[0]) begin
            $display("FAIL reset-test m0_gnt: got 0, required 1 within 20 cycles");
            to_req++;
        end
        pend1.push_back(mk(1'b0, IO_OUT_ADDR, SIZE_WORD, 32'h0));
        @(posedge clk);
        #2 rstn = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b1;
        drain(50);

        io_in = $urandom;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1, 0) == 0) pend0.push_back(rnd_txn());
            else                           pend1.push_back(rnd_txn());
            repeat ($urandom_range(3, 0)) @(posedge clk);
        end
        drain(1000);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single-port memory-mapped IO register block between two requesters: m0 (CPU load/store unit) and m1 (debug/loader port).
- Grants one access at a time and drives the IO block's we/addr/size/wd.
- The IO block returns rd one cycle after the address is presented; the arbiter routes that data and a completion pulse back to the granted requester.
- Sits between the core/debug masters and the IO register block.

Parameters:
- AW, 32, address width of requester and target ports.
- DW, 32, data width of requester and target ports.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- m0_req  in  1  requester 0 access request; level, held until m0_gnt
- m0_we  in  1  requester 0 write enable (1=write, 0=read)
- m0_addr  in  AW  requester 0 byte address
- m0_size  in  3  requester 0 access size code
- m0_wd  in  DW  requester 0 write data
- m0_gnt  out  1  requester 0 grant; 1-cycle pulse in the cycle the access is issued
- m0_rvalid  out  1  requester 0 completion; 1-cycle pulse, one cycle after m0_gnt
- m0_rd  out  DW  requester 0 read data; valid when m0_rvalid=1
- m1_req, m1_we, m1_addr, m1_size, m1_wd, m1_gnt, m1_rvalid, m1_rd: same as m0_* for requester 1
- t_we  out  1  target write enable
- t_addr  out  AW  target address
- t_size  out  3  target size code
- t_wd  out  DW  target write data
- t_rd  in  DW  target read data; registered by target, valid one cycle after t_addr

Behaviour:
- FSM states:
  - IDLE: no access in flight.
  - GRANT: issue cycle.
  - RESP: target data cycle.
- Registers: state, sel (1 bit, granted requester), last (1 bit, last granted requester).
- Reset values: state=IDLE, sel=0, last=1. All outputs read 0 in IDLE: gnt, rvalid, t_we=0; t_addr, t_size, t_wd, m*_rd=0.
- Arbitration: evaluated in IDLE and RESP.
  - If any req is asserted: next state=GRANT, sel=winner, last=winner.
  - Otherwise: next state=IDLE.
- GRANT (exactly 1 cycle):
  - t_we/t_addr/t_size/t_wd = fields of requester sel, combinational passthrough.
  - m{sel}_gnt=1.
  - Next state=RESP unconditionally.
- RESP (exactly 1 cycle):
  - m{sel}_rvalid=1 and m{sel}_rd=t_rd. The non-selected requester's rd=0.
  - rvalid pulses for writes too, as a completion; rd then carries whatever t_rd returns.
  - t_we=0; t_addr/t_size/t_wd=0.
- Latency: req seen in IDLE at cycle N -> gnt at N+1 -> rvalid at N+2.
- Back-to-back throughput: one access per 2 cycles (RESP->GRANT).
- Protocol rules:
  - A requester keeps req and all fields stable until it sees gnt.
  - A requester deasserts req in the cycle after gnt unless it is issuing a new request.
  - If req drops while its GRANT is in progress, the access still completes (gnt and rvalid still pulse).
- The non-selected requester's gnt and rvalid are never asserted in the same cycle as the selected requester's.
- No address decoding is done here; all addresses are forwarded. The target returns 0 for unmapped addresses.
- Reset asserted mid-access (GRANT or RESP): immediate return to IDLE, no rvalid, no write completes unless it was already sampled by the target.

Optional Feature:
- Macro IO_BUS_ARBITER_RR_EN.
- Defined: round-robin. When both req=1, the winner is the requester != last; when one requests, it wins.
- Undefined: fixed priority, m0 always wins when m0_req=1. The last register still updates but does not influence selection.

Decomposition:
- Shared package io_bus_pkg holds:
  - FSM state encodings (IDLE/GRANT/RESP).
  - IO address map constants: IO_IN_ADDR=32'h0000_0000, IO_OUT_ADDR=32'h0000_0004.
  - Access size code constants.
- One natural sub-module: io_arb_pick. Pure combinational 2-way winner select from req[1:0] and last, with the RR/fixed choice under the macro.

Test Plan:
- Reset, then idle 5 cycles -> all gnt/rvalid=0, t_we=0, t_addr=0.
- m0 write addr=0x4 wd=0xDEADBEEF at cycle N -> m0_gnt at N+1 with t_we=1, t_addr=0x4; m0_rvalid at N+2; subsequent m1 read of 0x4 returns m1_rd=0xDEADBEEF.
- m1 read 0x0 with io_in=0x12345678 -> m1_gnt at N+1, t_we=0; m1_rvalid at N+2 with m1_rd=0x12345678; m0_rvalid stays 0.
- Both req held continuously for 8 accesses:
  - RR_EN defined: grant order m0,m1,m0,m1,... with gnt every 2 cycles.
  - Undefined: m0 granted all 8 times, m1 starved.
- Reset pulsed low during RESP of an m0 read -> m0_rvalid not asserted, state IDLE, pending m1_req granted 1 cycle after reset release.
- m0 drops req during its GRANT cycle -> access still issued; m0_rvalid still pulses next cycle.
